sample_scheduler: RTL
=====================

Name: sample_scheduler

Overview:
- Sequences timestamped sensor sampling for the NeoPod avionics.
- On each 10 Hz timestamp tick, marks every enabled channel whose per-channel decimation count has expired as pending.
- Grants one channel at a time, round-robin, and latches the 24-bit timestamp for that sample.
- Sits between the timestamp counter and the sensor readout blocks; the sensor readout blocks share the single timestamp/sample path.

Parameters:
- NUM_CH, 4: number of sensor channels/requesters (2..8).
- DIV_W, 4: width of each per-channel decimation field.
- TS_W, 24: timestamp width.
- TIMEOUT_CYC, 1024: max CLK cycles in WAIT before abort (optional feature only).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- TICK  in  1  single-cycle strobe, one per 10 Hz timestamp increment (pre-synchronised to CLK).
- TIMESTAMP  in  TS_W  current timestamp count.
- CH_ENABLE  in  NUM_CH  per-channel enable.
- CH_DIV  in  NUM_CH*DIV_W  per-channel decimation; channel i uses bits [i*DIV_W +: DIV_W]; sample every CH_DIV+1 ticks.
- DONE  in  NUM_CH  single-cycle completion pulse from channel readout.
- START  out  NUM_CH  one-hot, single-cycle start pulse to the granted channel.
- SAMPLE_TS  out  TS_W  timestamp latched at grant; held until next grant.
- SAMPLE_CH  out  3  index of the last granted channel.
- ACTIVE  out  1  high while a channel is granted (START through DONE).
- OVERRUN  out  NUM_CH  sticky; channel was still pending when its next slot fired.

Behaviour:
- Reset values:
  - START=0, SAMPLE_TS=0, SAMPLE_CH=0, ACTIVE=0, OVERRUN=0.
  - All pending bits 0, all decimation counters 0.
  - Round-robin pointer = 0; state IDLE.
- Tick processing, in the cycle TICK=1, for each channel:
  - If CH_ENABLE[i]=0: counter cleared to 0 and pending cleared.
  - Else if counter==CH_DIV[i]: counter<=0 and the slot fires. If pending[i] is already 1, OVERRUN[i]<=1 and pending stays 1. Otherwise pending[i]<=1.
  - Else counter<=counter+1.
  - CH_DIV=0: the channel fires every tick.
  - A CH_DIV change takes effect at the next compare; a counter above the new CH_DIV keeps incrementing to its wrap (2^DIV_W) and then restarts at 0.
- FSM states: IDLE, GRANT, WAIT.
  - IDLE: if any pending bit is set, pick the first set bit at or after the pointer (wrapping), then go to GRANT. Otherwise stay in IDLE.
  - GRANT, one cycle:
    - START[sel]=1.
    - SAMPLE_TS<=TIMESTAMP; SAMPLE_CH<=sel.
    - pending[sel]<=0; pointer<=sel+1 mod NUM_CH.
    - ACTIVE<=1; go to WAIT.
  - WAIT: on DONE[sel]=1, ACTIVE<=0 and go to IDLE. DONE on any other channel is ignored.
- Latency:
  - Pending set at tick cycle T; START at the earliest T+2 (IDLE select at T+1, GRANT at T+2).
  - After DONE, the next START comes at the earliest 2 cycles later.
- Simultaneous events:
  - A TICK in the same cycle as GRANT that re-fires the granted channel: pending ends at 1 and OVERRUN is not set, because the clear-from-grant is applied before the set-from-tick.
  - A TICK during WAIT is processed normally.
- Disable mid-operation:
  - CH_ENABLE[sel] dropping during WAIT does not abort; the FSM still waits for DONE.
  - A pending-but-not-granted channel that is disabled is dropped.
- RESET mid-operation: returns to IDLE immediately. No START is issued in the reset cycle, and outstanding DONE pulses are ignored.
- SAMPLE_TS is a straight copy of TIMESTAMP; the block does no timestamp arithmetic.

Optional Feature:
- Macro: SAMPLE_SCHED_TIMEOUT_EN.
- With the macro defined:
  - Adds output TIMEOUT_ERR (NUM_CH, sticky, reset 0) and an internal WAIT cycle counter.
  - If TIMEOUT_CYC cycles elapse in WAIT without DONE[sel]: TIMEOUT_ERR[sel]<=1, ACTIVE<=0, go to IDLE. A later stray DONE is ignored.
- Without the macro: no port, no counter; WAIT persists until DONE or RESET.

Decomposition:
- Shared package sample_sched_pkg holds:
  - State encoding constants: IDLE=2'd0, GRANT=2'd1, WAIT=2'd2.
  - TS_W default.
  - Channel index width function (clog2 of NUM_CH).
- One natural sub-module, rr_pick: combinational round-robin first-set-bit finder taking pending and pointer, returning sel and valid.

Test Plan:
- Single channel: NUM_CH=4, CH_ENABLE=4'b0001, CH_DIV[0]=0, TIMESTAMP=24'h000010, TICK at cycle 10.
  - START=4'b0001 at cycle 12, SAMPLE_TS=24'h000010, SAMPLE_CH=0.
  - DONE at 15 -> ACTIVE falls at 16.
- Round-robin: all channels enabled, CH_DIV=0, one TICK, DONE 2 cycles after each START.
  - START order 0,1,2,3.
  - Next tick order restarts at 0 (pointer=0 after ch3); OVERRUN=0.
- Decimation: ch2 CH_DIV=3, 12 ticks -> exactly 3 START[2] pulses, on ticks 4, 8 and 12.
- Overrun: ch1 CH_DIV=0, DONE withheld across 2 ticks.
  - OVERRUN[1]=1 after the second tick; pending stays 1.
  - After DONE, exactly one further START[1].
- Reset mid-WAIT: RESET during WAIT on ch3.
  - Next cycle: ACTIVE=0, pending=0, OVERRUN=0.
  - DONE[3] afterwards produces no state change.
- With SAMPLE_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16: grant ch0, no DONE.
  - TIMEOUT_ERR[0]=1 and ACTIVE=0 after 16 WAIT cycles.
  - A pending ch1 is granted 2 cycles later.

Source files
------------

// File: rtl/sample_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sample_sched_pkg : shared types and helpers for the sample scheduler        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package sample_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam int c_TS_W_DEFAULT = 24;

   // Channel index width; never narrower than one bit.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sample_scheduler_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin finder, first set bit at/after i_ptr    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module rr_pick
   import sample_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = ch_idx_w(NUM_CH)
)(
   input  logic [NUM_CH-1:0] i_pend,
   input  logic [IDX_W-1:0]  i_ptr,
   output logic [IDX_W-1:0]  o_sel,
   output logic              o_valid
);

   logic [IDX_W-1:0] w_idx;

   // Scan from the farthest offset back towards the pointer so the nearest hit wins.
   always_comb begin
      o_sel   = '0;
      o_valid = 1'b0;
      w_idx   = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         w_idx = IDX_W'((int'(i_ptr) + k) % NUM_CH);
         if (i_pend[w_idx]) begin
            o_sel   = w_idx;
            o_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sample_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sample_scheduler : tick-driven decimated sampling, round-robin grant with   |
// | timestamp latch. Optional WAIT timeout via SAMPLE_SCHED_TIMEOUT_EN.         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sample_scheduler
   import sample_sched_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 4,
   parameter int TS_W        = c_TS_W_DEFAULT,
   parameter int TIMEOUT_CYC = 1024
)(
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    TICK,
   input  logic [TS_W-1:0]         TIMESTAMP,
   input  logic [NUM_CH-1:0]       CH_ENABLE,
   input  logic [NUM_CH*DIV_W-1:0] CH_DIV,
   input  logic [NUM_CH-1:0]       DONE,
   output logic [NUM_CH-1:0]       START,
   output logic [TS_W-1:0]         SAMPLE_TS,
   output logic [2:0]              SAMPLE_CH,
   output logic                    ACTIVE,
`ifdef SAMPLE_SCHED_TIMEOUT_EN
   output logic [NUM_CH-1:0]       TIMEOUT_ERR,
`endif
   output logic [NUM_CH-1:0]       OVERRUN
);

   localparam int c_IDX_W = ch_idx_w(NUM_CH);

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [c_IDX_W-1:0]           r_sel;
   logic [c_IDX_W-1:0]           r_ptr;
   logic [c_IDX_W-1:0]           w_pick;
   logic                         w_pick_vld;
   logic [NUM_CH-1:0]            r_pend;
   logic [NUM_CH-1:0]            w_pend_nxt;
   logic [NUM_CH-1:0]            r_ovr;
   logic [NUM_CH-1:0]            w_ovr_nxt;
   logic [NUM_CH-1:0][DIV_W-1:0] r_cnt;
   logic [NUM_CH-1:0][DIV_W-1:0] w_cnt_nxt;
   logic [NUM_CH-1:0]            w_grant_oh;
   logic [NUM_CH-1:0]            w_start;
   logic [TS_W-1:0]              r_sample_ts;
   logic [2:0]                   r_sample_ch;
   logic                         r_active;
   logic                         w_done_sel;
   logic                         w_timeout;

   generate
      if (NUM_CH < 2 || NUM_CH > 8 || DIV_W < 1 || TS_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
         $error("sample_scheduler: parameter out of range");
      end
   endgenerate

   rr_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (c_IDX_W)
   ) u_rr_pick (
      .i_pend  (r_pend),
      .i_ptr   (r_ptr),
      .o_sel   (w_pick),
      .o_valid (w_pick_vld)
   );

   assign w_done_sel = DONE[r_sel];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // START is decoded from state, so it must be masked in a reset cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_oh  = '0;
      w_start     = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_vld) begin
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            w_grant_oh[r_sel] = 1'b1;
            if (!RESET) begin
               w_start[r_sel] = 1'b1;
            end
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_done_sel || w_timeout) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Grant clear lands first, so a re-fire of the granted channel is not an overrun.
   always_comb begin
      w_pend_nxt = r_pend & ~w_grant_oh;
      w_ovr_nxt  = r_ovr;
      w_cnt_nxt  = r_cnt;
      if (TICK) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!CH_ENABLE[i]) begin
               w_cnt_nxt[i]  = '0;
               w_pend_nxt[i] = 1'b0;
            end else if (r_cnt[i] == CH_DIV[i*DIV_W +: DIV_W]) begin
               w_cnt_nxt[i] = '0;
               if (w_pend_nxt[i]) begin
                  w_ovr_nxt[i] = 1'b1;
               end
               w_pend_nxt[i] = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_pend      <= '0;
         r_ovr       <= '0;
         r_cnt       <= '0;
         r_sel       <= '0;
         r_ptr       <= '0;
         r_sample_ts <= '0;
         r_sample_ch <= '0;
         r_active    <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
         r_ovr  <= w_ovr_nxt;
         r_cnt  <= w_cnt_nxt;
         if (r_state == ST_IDLE && w_pick_vld) begin
            r_sel <= w_pick;
         end
         if (r_state == ST_GRANT) begin
            r_sample_ts <= TIMESTAMP;
            r_sample_ch <= 3'(r_sel);
            r_ptr       <= (r_sel == c_IDX_W'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;
            r_active    <= 1'b1;
         end else if (r_state == ST_WAIT && w_state_nxt == ST_IDLE) begin
            r_active <= 1'b0;
         end
      end
   end

`ifdef SAMPLE_SCHED_TIMEOUT_EN
   localparam int c_WCNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [c_WCNT_W-1:0] r_wcnt;
   logic [NUM_CH-1:0]   r_tmo_err;

   // r_wcnt holds the number of WAIT cycles already spent before this one.
   assign w_timeout = (r_state == ST_WAIT) && !w_done_sel &&
                      (r_wcnt == c_WCNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_wcnt    <= '0;
         r_tmo_err <= '0;
      end else begin
         if (r_state == ST_GRANT) begin
            r_wcnt <= '0;
         end else if (r_state == ST_WAIT) begin
            r_wcnt <= r_wcnt + 1'b1;
         end
         if (w_timeout) begin
            r_tmo_err[r_sel] <= 1'b1;
         end
      end
   end

   assign TIMEOUT_ERR = r_tmo_err;
`else
   assign w_timeout = 1'b0;
`endif

   assign START     = w_start;
   assign SAMPLE_TS = r_sample_ts;
   assign SAMPLE_CH = r_sample_ch;
   assign ACTIVE    = r_active;
   assign OVERRUN   = r_ovr;

endmodule
`default_nettype wire
